pwm_demod: RTL and testbench

//   Downstream stage of the PWM generator: recovers the 8-bit duty value from a serial PWM line.

---
 rtl/pwm_demod.sv | 192 +++++++++++++++++++
 tb/tb_pwm_demod.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_demod.sv
// ---------------------------------------------------------------------------
// pwm_demod
//   Recovers an N-bit duty value from a serial PWM line. High samples are
//   counted over consecutive windows of PERIOD = 2**WIDTH enabled clocks.
//   Each count is published once per window. Lock is declared when two
//   consecutive complete windows produce the same value.
//
// Parameters
//   WIDTH          result width; the window length is 2**WIDTH clocks
//
// Ports
//   i_clk          single clock, all logic on posedge
//   i_rst          synchronous active-high reset, highest priority
//   i_en           measurement enable; low holds results, aborts window
//   i_sin          PWM serial input
//   o_dout         high-sample count of the last complete window
//                  (saturates at PERIOD-1)
//   o_dout_valid   one-cycle pulse, o_dout was updated this cycle
//   o_locked       last two complete windows gave identical o_dout
//   o_ovf          last window saw PERIOD high samples
//
// Configuration
//   PWM_DEMOD_SYNC_EN   when defined, i_sin passes through a two-flop
//                       synchroniser (reset to 0) before it is counted.
//                       Window contents shift by two cycles; the pulse
//                       timing relative to reset does not change.
// ---------------------------------------------------------------------------
module pwm_demod #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_sin,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_dout_valid,
  output logic             o_locked,
  output logic             o_ovf
);

  // A full window is PERIOD samples. The last window position is all ones.
  // A full-scale sum is exactly PERIOD and needs the extra accumulator bit.
  localparam int               PERIOD    = 2 ** WIDTH;
  localparam logic [WIDTH-1:0] WCNT_LAST = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] DOUT_SAT  = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]   SUM_FULL  = (WIDTH + 1)'(PERIOD);
  localparam logic [WIDTH-1:0] WCNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Datapath and FSM registers
  logic [WIDTH-1:0] r_wcnt;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_ovf;
  logic             r_locked;
  state_t           r_state;

  // Combinational helpers
  logic             w_sample;
  logic             w_window_end;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_new_dout;
  logic             w_new_ovf;
  logic             w_match;
  state_t           w_state_next;
  logic             w_locked_next;

`ifdef PWM_DEMOD_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Two-flop synchroniser for an asynchronous PWM source. It runs whether or
  // not the measurement is enabled, so the first two samples after reset
  // read as 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_sin;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sample = r_sync2;
`else
  // The source is on this clock, so it is sampled directly.
  assign w_sample = i_sin;
`endif

  // The window closes on the last enabled position. The final sample still
  // has to be counted, so the published result is built from acc + sample
  // rather than from acc alone.
  always_comb begin
    w_window_end = i_en && (r_wcnt == WCNT_LAST);
    w_sum        = r_acc + {{WIDTH{1'b0}}, w_sample};
    w_new_ovf    = (w_sum == SUM_FULL);
    w_new_dout   = (w_sum >= SUM_FULL) ? DOUT_SAT : w_sum[WIDTH-1:0];
    w_match      = (w_new_dout == r_prev);
  end

  // Lock FSM next-state logic. Dropping enable returns to IDLE without a
  // result. Otherwise the FSM moves only when a window closes. In IDLE there
  // is no earlier window, so r_prev is ignored.
  always_comb begin
    w_state_next  = r_state;
    w_locked_next = r_locked;
    if (!i_en) begin
      w_state_next  = ST_IDLE;
      w_locked_next = 1'b0;
    end else if (w_window_end) begin
      case (r_state)
        ST_IDLE: begin
          w_state_next  = ST_ACQUIRE;
          w_locked_next = 1'b0;
        end
        ST_ACQUIRE: begin
          if (w_match) begin
            w_state_next  = ST_LOCKED;
            w_locked_next = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!w_match) begin
            w_state_next  = ST_ACQUIRE;
            w_locked_next = 1'b0;
          end
        end
        default: begin
          w_state_next  = ST_IDLE;
          w_locked_next = 1'b0;
        end
      endcase
    end
  end

  // State register and lock flag. Lock updates on the same edge as the
  // result pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_locked <= w_locked_next;
    end
  end

  // Window counter, accumulator and published result. Reset beats enable,
  // and enable-low beats a window end, so a window cut short by either is
  // discarded silently. dout and ovf keep their last published values until
  // a window completes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wcnt       <= '0;
      r_acc        <= '0;
      r_prev       <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_ovf        <= 1'b0;
    end else if (!i_en) begin
      r_wcnt       <= '0;
      r_acc        <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_wcnt <= r_wcnt + WCNT_ONE;
      if (w_window_end) begin
        r_acc        <= '0;
        r_dout       <= w_new_dout;
        r_prev       <= w_new_dout;
        r_ovf        <= w_new_ovf;
        r_dout_valid <= 1'b1;
      end else begin
        r_acc        <= w_sum;
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign o_dout       = r_dout;
  assign o_dout_valid = r_dout_valid;
  assign o_locked     = r_locked;
  assign o_ovf        = r_ovf;

endmodule

// File: tb/tb_pwm_demod.sv
// ---------------------------------------------------------------------------
// tb_pwm_demod
//   Self-checking bench for pwm_demod (WIDTH=8).
//   Every cycle, all outputs are compared with a window-level reference model
//   that counts samples since the window opened. Table-driven constant-duty
//   vectors and hand-written sequences cover latency, the duty change, the
//   mid-window reset and enable drop. A randomised run follows.
// ---------------------------------------------------------------------------
module tb_pwm_demod;

  localparam int WIDTH  = 8;
  localparam int PERIOD = 256;
`ifdef PWM_DEMOD_SYNC_EN
  localparam int FIRST_W = 1;
`else
  localparam int FIRST_W = 0;
`endif

  logic             clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_en = 1'b0;
  logic             i_sin = 1'b0;
  logic [WIDTH-1:0] o_dout;
  logic             o_dout_valid;
  logic             o_locked;
  logic             o_ovf;

  int nChecks = 0;
  int nFail   = 0;

  // PWM source
  int pwmDuty  = 0;
  int pwmPhase = 0;

  // Reference model state
  int mSamp    = 0;
  int mSync1   = 0;
  int mSync2   = 0;
  int mPos     = 0;
  int mCount   = 0;
  int mWindows = 0;
  int mPrev    = 0;
  int mDout    = 0;
  int mOvf     = 0;
  int mValid   = 0;
  int mLocked  = 0;

  typedef struct {
    int duty;
    int phase;
    int expDout;
    int expOvf;
  } vec_t;

  vec_t vecs[7];

  pwm_demod #(.WIDTH(WIDTH)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .i_sin        (i_sin),
    .o_dout       (o_dout),
    .o_dout_valid (o_dout_valid),
    .o_locked     (o_locked),
    .o_ovf        (o_ovf)
  );

  always #5 clk = ~clk;

  // Window-level reference model. A window is PERIOD consecutive enabled
  // samples. Its result is the number of ones, clipped to PERIOD-1. Lock
  // means this result matches the previous one, with no reset or enable drop
  // in between.
  always @(posedge clk) begin
    if (i_rst) begin
      mSync1 = 0; mSync2 = 0; mPos = 0; mCount = 0; mWindows = 0;
      mPrev = 0; mDout = 0; mOvf = 0; mValid = 0; mLocked = 0;
    end else begin
`ifdef PWM_DEMOD_SYNC_EN
      mSamp  = mSync2;
      mSync2 = mSync1;
      mSync1 = int'(i_sin);
`else
      mSamp  = int'(i_sin);
`endif
      if (!i_en) begin
        mPos = 0; mCount = 0; mWindows = 0; mValid = 0; mLocked = 0;
      end else begin
        mCount = mCount + mSamp;
        mPos   = mPos + 1;
        mValid = 0;
        if (mPos == PERIOD) begin
          mDout    = (mCount > PERIOD - 1) ? PERIOD - 1 : mCount;
          mOvf     = (mCount == PERIOD) ? 1 : 0;
          mLocked  = (mWindows >= 1 && mDout == mPrev) ? 1 : 0;
          mPrev    = mDout;
          mWindows = mWindows + 1;
          mValid   = 1;
          mPos     = 0;
          mCount   = 0;
        end
      end
    end
  end

  // One comparison: counts it, and reports a mismatch.
  task automatic checkVal(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFail++;
      $display("[TB] FAIL %s at t=%0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Compare every output with the reference model.
  task automatic checkOutput();
    checkVal("model dout", int'(o_dout), mDout);
    checkVal("model dout_valid", int'(o_dout_valid), mValid);
    checkVal("model locked", int'(o_locked), mLocked);
    checkVal("model ovf", int'(o_ovf), mOvf);
  endtask

  // Drive one cycle away from the edge, then check just after the edge.
  task automatic applyStimulus(input logic rst, input logic en, input logic sin);
    @(negedge clk);
    i_rst = rst;
    i_en  = en;
    i_sin = sin;
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // The next PWM bit: high for the first pwmDuty positions of each 256-cycle
  // period.
  task automatic nextPwm(output logic b);
    b = (pwmPhase < pwmDuty);
    pwmPhase = (pwmPhase + 1) % PERIOD;
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
  endtask

  task automatic runPwm(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      nextPwm(b);
      applyStimulus(1'b0, 1'b1, b);
    end
  endtask

  // Run PWM stimulus until a result pulse appears.
  // cycles = number of enabled steps taken, or -1 if maxCycles ran out.
  task automatic runUntilValid(input int maxCycles, output int cycles);
    logic b;
    cycles = -1;
    for (int i = 1; i <= maxCycles; i++) begin
      nextPwm(b);
      applyStimulus(1'b0, 1'b1, b);
      if (o_dout_valid) begin
        cycles = i;
        break;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int mode;
    int len;
    logic b;
    logic sinBit;
    logic enBit;
    logic rstBit;

    vecs[0] = '{duty: 0,   phase: 0,   expDout: 0,   expOvf: 0};
    vecs[1] = '{duty: 100, phase: 37,  expDout: 100, expOvf: 0};
    vecs[2] = '{duty: 256, phase: 0,   expDout: 255, expOvf: 1};
    vecs[3] = '{duty: 1,   phase: 200, expDout: 1,   expOvf: 0};
    vecs[4] = '{duty: 255, phase: 5,   expDout: 255, expOvf: 0};
    vecs[5] = '{duty: 128, phase: 128, expDout: 128, expOvf: 0};
    vecs[6] = '{duty: 37,  phase: 250, expDout: 37,  expOvf: 0};

    $display("[TB] start");

    // Reset state
    doReset();
    checkVal("reset dout", int'(o_dout), 0);
    checkVal("reset dout_valid", int'(o_dout_valid), 0);
    checkVal("reset locked", int'(o_locked), 0);
    checkVal("reset ovf", int'(o_ovf), 0);

    // Constant-duty vectors: each one runs three windows from a fresh reset.
    for (int v = 0; v < 7; v++) begin
      doReset();
      pwmDuty  = vecs[v].duty;
      pwmPhase = vecs[v].phase;
      for (int w = 0; w < 3; w++) begin
        runUntilValid(300, cyc);
        checkVal($sformatf("vec%0d w%0d window length", v, w), cyc, PERIOD);
        if (w >= FIRST_W) begin
          checkVal($sformatf("vec%0d w%0d dout", v, w), int'(o_dout), vecs[v].expDout);
          checkVal($sformatf("vec%0d w%0d ovf", v, w), int'(o_ovf), vecs[v].expOvf);
        end
        if (w == 0)
          checkVal($sformatf("vec%0d w0 locked", v), int'(o_locked), 0);
        else if (w >= FIRST_W + 1)
          checkVal($sformatf("vec%0d w%0d locked", v, w), int'(o_locked), 1);
      end
    end

    // Duty change mid-window while locked at 100
    doReset();
    pwmDuty  = 100;
    pwmPhase = 77;
    runUntilValid(300, cyc);
    runUntilValid(300, cyc);
    checkVal("dchg locked before", int'(o_locked), 1);
    runPwm(100);
    pwmDuty = 37;
    runUntilValid(300, cyc);
    checkVal("dchg straddle length", cyc, PERIOD - 100);
    checkVal("dchg straddle in 37..100", int'(o_dout >= 37 && o_dout <= 100), 1);
    runUntilValid(300, cyc);
    checkVal("dchg next dout", int'(o_dout), 37);
    runUntilValid(300, cyc);
    checkVal("dchg relock dout", int'(o_dout), 37);
    checkVal("dchg relock locked", int'(o_locked), 1);

    // Reset pulse at wcnt=128
    runPwm(128);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkVal("midrst dout", int'(o_dout), 0);
    checkVal("midrst valid", int'(o_dout_valid), 0);
    checkVal("midrst locked", int'(o_locked), 0);
    checkVal("midrst ovf", int'(o_ovf), 0);
    runUntilValid(400, cyc);
    checkVal("midrst next window length", cyc, PERIOD);
    checkVal("midrst first locked", int'(o_locked), 0);
    runUntilValid(300, cyc);
    checkVal("midrst second dout", int'(o_dout), 37);

    // Enable drop on the last window position
    runPwm(255);
    nextPwm(b);
    applyStimulus(1'b0, 1'b0, b);
    checkVal("endrop valid", int'(o_dout_valid), 0);
    checkVal("endrop dout hold", int'(o_dout), 37);
    checkVal("endrop locked", int'(o_locked), 0);
    runUntilValid(400, cyc);
    checkVal("endrop next window length", cyc, PERIOD);
    checkVal("endrop next dout", int'(o_dout), 37);

    // Randomised segments: PWM, noise and glitchy PWM, with rare enable drops
    // and resets. The model checks every cycle.
    doReset();
    for (int seg = 0; seg < 16; seg++) begin
      mode     = int'($urandom_range(0, 2));
      pwmDuty  = int'($urandom_range(0, 256));
      pwmPhase = int'($urandom_range(0, 255));
      len      = int'($urandom_range(200, 900));
      for (int i = 0; i < len; i++) begin
        nextPwm(b);
        case (mode)
          0:       sinBit = b;
          1:       sinBit = logic'($urandom_range(0, 1));
          default: sinBit = b ^ ($urandom_range(0, 15) == 0);
        endcase
        enBit  = ($urandom_range(0, 1499) != 0);
        rstBit = ($urandom_range(0, 2999) == 0);
        applyStimulus(rstBit, enBit, sinBit);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
